wallace_product_accumulator: RTL and testbench

- Sequential stage directly downstream of the 8x8 Wallace tree multiplier.
- Consumes its 16-bit unsigned products and accumulates them into a dot-product sum.
- Input vectors are delimited by a last flag. Each completed sum is presented on a valid/ready output port.
- The registered sum, term count and overflow flag are what the downstream datapath or register file reads.

---
 rtl/wallace_product_accumulator.sv | 102 ++++++++++
 tb/tb_wallace_product_accumulator.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wallace_product_accumulator.sv
// Dot-product accumulator downstream of the 8x8 Wallace multiplier: sums unsigned
// products until p_last, then presents sum, term count and overflow on a valid/ready port.
module wallace_product_accumulator #(
  parameter int PW  = 16,
  parameter int AW  = 24,
  parameter bit SAT = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [PW-1:0] p_in,
  input  logic          p_valid,
  input  logic          p_last,
  output logic          p_ready,
  output logic [AW-1:0] acc_out,
  output logic [7:0]    acc_cnt,
  output logic          acc_ovf,
  output logic          acc_valid,
  input  logic          acc_ready
);

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  state_t state, state_next;

  logic [AW-1:0] sum_q;
  logic [7:0]    cnt_q;
  logic          ovf_q;

  logic [AW:0]   add_full;
  logic          carry;
  logic [AW-1:0] sum_next;
  logic [7:0]    cnt_next;
  logic          ovf_next;
  logic          xfer;
  logic          handshake;

  // Holding p_ready low during reset keeps upstream from treating the reset edge as a transfer.
  assign p_ready   = rst_n && (state == ST_ACC);
  assign xfer      = p_valid && p_ready;
  assign handshake = acc_valid && acc_ready;

  // Running sum including the current term, with the carry folded into the overflow flag.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    add_full = (AW+1)'(sum_q) + (AW+1)'(p_in);
    carry    = add_full[AW];
    ovf_next = ovf_q | carry;
    sum_next = add_full[AW-1:0];
    if (SAT && ovf_next) begin
      sum_next = '1;
    end
    cnt_next = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_ACC:  if (xfer && p_last) state_next = ST_OUT;
      ST_OUT:  if (handshake)      state_next = ST_ACC;
      default:                     state_next = ST_ACC;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_ACC;
      sum_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      acc_out   <= '0;
      acc_cnt   <= '0;
      acc_ovf   <= 1'b0;
      acc_valid <= 1'b0;
    end else begin
      state <= state_next;
      if (xfer) begin
        if (p_last) begin
          acc_out   <= sum_next;
          acc_cnt   <= cnt_next;
          acc_ovf   <= ovf_next;
          acc_valid <= 1'b1;
          sum_q     <= '0;
          cnt_q     <= '0;
          ovf_q     <= 1'b0;
        end else begin
          sum_q <= sum_next;
          cnt_q <= cnt_next;
          ovf_q <= ovf_next;
        end
      end
      // Result fields stay put after the handshake; only the valid flag drops.
      if (handshake) begin
        acc_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wallace_product_accumulator.sv
// Bench for wallace_product_accumulator: default, 16-bit saturating and 16-bit wrapping
// instances share stimulus and are compared against a whole-vector arithmetic model.
module tb_wallace_product_accumulator;

  localparam int PW = 16;
  typedef logic [85:0] res_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] p_in = '0;
  logic          p_valid = 1'b0;
  logic          p_last = 1'b0;
  logic          acc_ready = 1'b1;

  logic          pr_d, pr_s, pr_w;
  logic [23:0]   out_d;
  logic [15:0]   out_s, out_w;
  logic [7:0]    cnt_d, cnt_s, cnt_w;
  logic          ovf_d, ovf_s, ovf_w;
  logic          val_d, val_s, val_w;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  res_t       obs;
  logic [2:0] rdy;
  assign obs = {val_d, val_s, val_w, out_d, cnt_d, ovf_d, out_s, cnt_s, ovf_s, out_w, cnt_w, ovf_w};
  assign rdy = {pr_d, pr_s, pr_w};

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  wallace_product_accumulator dut_d (
    .clk(clk), .rst_n(rst_n), .p_in(p_in), .p_valid(p_valid), .p_last(p_last),
    .p_ready(pr_d), .acc_out(out_d), .acc_cnt(cnt_d), .acc_ovf(ovf_d),
    .acc_valid(val_d), .acc_ready(acc_ready)
  );

  wallace_product_accumulator #(.PW(16), .AW(16), .SAT(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .p_in(p_in), .p_valid(p_valid), .p_last(p_last),
    .p_ready(pr_s), .acc_out(out_s), .acc_cnt(cnt_s), .acc_ovf(ovf_s),
    .acc_valid(val_s), .acc_ready(acc_ready)
  );

  wallace_product_accumulator #(.PW(16), .AW(16), .SAT(1'b0)) dut_w (
    .clk(clk), .rst_n(rst_n), .p_in(p_in), .p_valid(p_valid), .p_last(p_last),
    .p_ready(pr_w), .acc_out(out_w), .acc_cnt(cnt_w), .acc_ovf(ovf_w),
    .acc_valid(val_w), .acc_ready(acc_ready)
  );

  // Whole-vector model: overflow iff the exact total reaches 2^AW (terms are non-negative).
  function automatic res_t expect_res(input int terms[$], input bit valid);
    longint total = 0;
    longint s24, s16s, s16w;
    bit o24, o16;
    logic [7:0] c;
    foreach (terms[i]) total += longint'(terms[i]);
    c    = (terms.size() > 255) ? 8'd255 : 8'(terms.size());
    o24  = total >= (longint'(1) << 24);
    s24  = o24 ? (longint'(1) << 24) - 1 : total;
    o16  = total >= 65536;
    s16s = o16 ? 65535 : total;
    s16w = total % 65536;
    return {{3{valid}}, 24'(s24), c, o24, 16'(s16s), c, o16, 16'(s16w), c, o16};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one vector; returns at the sample point just after the final transfer.
  task automatic drive_vector(input int terms[$], input bit with_last, input bit gaps,
                              output bit timed_out, output bit early_valid);
    int guard;
    timed_out   = 1'b0;
    early_valid = 1'b0;
    foreach (terms[i]) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          p_valid = 1'b0;
          p_in    = 16'($urandom);
          p_last  = 1'($urandom);
          tick();
        end
      end
      p_valid = 1'b1;
      p_in    = 16'(terms[i]);
      p_last  = with_last && (i == terms.size() - 1);
      guard   = 0;
      while (!pr_d && guard < 50) begin
        tick();
        guard++;
      end
      if (guard >= 50) timed_out = 1'b1;
      tick();
      if (!p_last && (val_d || val_s || val_w)) early_valid = 1'b1;
    end
    p_valid = 1'b0;
    p_last  = 1'b0;
  endtask

  task automatic test_reset;
    int none[$];
    rst_n = 1'b0; p_valid = 1'b1; p_in = 16'h1234; p_last = 1'b1; acc_ready = 1'b0;
    tick();
    tick();
    vectors++;
    if (rdy !== 3'b000) begin
      $display("FAIL reset_p_ready: got %b want 000", rdy); miscompares++;
    end
    vectors++;
    if (obs !== expect_res(none, 1'b0)) begin
      $display("FAIL reset_outputs: got %h want %h", obs, expect_res(none, 1'b0)); miscompares++;
    end
    p_valid = 1'b0; p_last = 1'b0; rst_n = 1'b1;
    #1;
    vectors++;
    if (rdy !== 3'b111) begin
      $display("FAIL release_p_ready: got %b want 111", rdy); miscompares++;
    end
    acc_ready = 1'b1;
  endtask

  task automatic test_three_term;
    int q[$];
    bit to, ev;
    q.push_back(65025); q.push_back(65025); q.push_back(65025);
    acc_ready = 1'b1;
    drive_vector(q, 1'b1, 1'b0, to, ev);
    vectors++;
    if (to || ev) begin
      $display("FAIL three_term_protocol: timeout=%0b early_valid=%0b want 0 0", to, ev); miscompares++;
    end
    vectors++;
    if (obs !== expect_res(q, 1'b1) || out_d !== 24'd195075) begin
      $display("FAIL three_term_result: got %h want %h", obs, expect_res(q, 1'b1)); miscompares++;
    end
    vectors++;
    if (rdy !== 3'b000) begin
      $display("FAIL three_term_busy: got %b want 000", rdy); miscompares++;
    end
    tick();
    vectors++;
    if (obs !== expect_res(q, 1'b0) || rdy !== 3'b111) begin
      $display("FAIL three_term_release: got %h/%b want %h/111", obs, rdy, expect_res(q, 1'b0)); miscompares++;
    end
  endtask

  task automatic test_backpressure;
    int q[$];
    int one[$];
    bit to, ev;
    q.push_back(65025); q.push_back(65025); q.push_back(65025);
    acc_ready = 1'b0;
    drive_vector(q, 1'b1, 1'b0, to, ev);
    p_valid = 1'b1; p_in = 16'hBEEF; p_last = 1'b1;
    for (int s = 0; s < 5; s++) begin
      vectors++;
      if (obs !== expect_res(q, 1'b1) || rdy !== 3'b000 || to || ev) begin
        $display("FAIL backpressure_hold[%0d]: got %h/%b want %h/000", s, obs, rdy, expect_res(q, 1'b1));
        miscompares++;
      end
      if (s < 4) tick();
    end
    acc_ready = 1'b1;
    tick();
    p_valid = 1'b0; p_last = 1'b0;
    vectors++;
    if (obs !== expect_res(q, 1'b0) || rdy !== 3'b111) begin
      $display("FAIL backpressure_release: got %h/%b want %h/111", obs, rdy, expect_res(q, 1'b0)); miscompares++;
    end
    one.push_back(11);
    drive_vector(one, 1'b1, 1'b0, to, ev);
    vectors++;
    if (obs !== expect_res(one, 1'b1) || to || ev) begin
      $display("FAIL backpressure_no_consume: got %h want %h", obs, expect_res(one, 1'b1)); miscompares++;
    end
    tick();
  endtask

  task automatic test_overflow;
    int q[$];
    int one[$];
    bit to, ev;
    q.push_back(65025); q.push_back(1000);
    drive_vector(q, 1'b1, 1'b0, to, ev);
    vectors++;
    if (obs !== expect_res(q, 1'b1) || to || ev) begin
      $display("FAIL overflow_result: got %h want %h", obs, expect_res(q, 1'b1)); miscompares++;
    end
    vectors++;
    if (out_s !== 16'd65535 || out_w !== 16'd489 || {ovf_s, ovf_w, ovf_d} !== 3'b110 || cnt_s !== 8'd2) begin
      $display("FAIL overflow_values: got sat=%0d wrap=%0d ovf=%b cnt=%0d want 65535 489 110 2",
               out_s, out_w, {ovf_s, ovf_w, ovf_d}, cnt_s);
      miscompares++;
    end
    tick();
    one.push_back(5);
    drive_vector(one, 1'b1, 1'b0, to, ev);
    vectors++;
    if (obs !== expect_res(one, 1'b1) || to || ev) begin
      $display("FAIL overflow_next_vector: got %h want %h", obs, expect_res(one, 1'b1)); miscompares++;
    end
    tick();
  endtask

  task automatic test_reset_mid;
    int q[$];
    int one[$];
    int none[$];
    bit to, ev;
    q.push_back(100); q.push_back(200);
    drive_vector(q, 1'b0, 1'b0, to, ev);
    rst_n = 1'b0;
    tick();
    vectors++;
    if (obs !== expect_res(none, 1'b0) || rdy !== 3'b000 || to || ev) begin
      $display("FAIL reset_mid_cleared: got %h/%b want %h/000", obs, rdy, expect_res(none, 1'b0)); miscompares++;
    end
    rst_n = 1'b1;
    one.push_back(7);
    drive_vector(one, 1'b1, 1'b0, to, ev);
    vectors++;
    if (obs !== expect_res(one, 1'b1) || to || ev) begin
      $display("FAIL reset_mid_next: got %h want %h", obs, expect_res(one, 1'b1)); miscompares++;
    end
    tick();
  endtask

  task automatic test_back_to_back;
    int vals[3] = '{3, 4, 9};
    int one[$];
    int prev = 0;
    int guard;
    acc_ready = 1'b1; p_valid = 1'b1; p_last = 1'b1; p_in = 16'(vals[0]);
    for (int k = 0; k < 3; k++) begin
      guard = 0;
      while (!pr_d && guard < 10) begin
        tick();
        guard++;
      end
      tick();
      if (k > 0) begin
        vectors++;
        if (cycle - prev != 2 || guard != 0) begin
          $display("FAIL back_to_back_spacing[%0d]: got %0d cycles want 2", k, cycle - prev); miscompares++;
        end
      end
      prev = cycle;
      one.delete();
      one.push_back(vals[k]);
      vectors++;
      if (obs !== expect_res(one, 1'b1)) begin
        $display("FAIL back_to_back_result[%0d]: got %h want %h", k, obs, expect_res(one, 1'b1)); miscompares++;
      end
      if (k < 2) p_in = 16'(vals[k+1]);
      tick();
    end
    p_valid = 1'b0; p_last = 1'b0;
  endtask

  task automatic test_count_saturation;
    int q[$];
    bit to, ev;
    for (int i = 0; i < 260; i++) q.push_back(65535);
    acc_ready = 1'b1;
    drive_vector(q, 1'b1, 1'b0, to, ev);
    vectors++;
    if (obs !== expect_res(q, 1'b1) || cnt_d !== 8'd255 || out_d !== 24'hFFFFFF || to || ev) begin
      $display("FAIL count_saturation: got %h want %h", obs, expect_res(q, 1'b1)); miscompares++;
    end
    tick();
  endtask

  task automatic test_random;
    int q[$];
    int stall;
    bit to, ev;
    for (int v = 0; v < 25; v++) begin
      q.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++)
        q.push_back(($urandom_range(0, 3) == 0) ? 65535 : int'($urandom_range(0, 65535)));
      stall = $urandom_range(0, 3);
      acc_ready = (stall == 0);
      drive_vector(q, 1'b1, 1'b1, to, ev);
      vectors++;
      if (obs !== expect_res(q, 1'b1) || rdy !== 3'b000 || to || ev) begin
        $display("FAIL random_result[%0d]: got %h/%b want %h/000", v, obs, rdy, expect_res(q, 1'b1)); miscompares++;
      end
      for (int s = 1; s < stall; s++) begin
        tick();
        vectors++;
        if (obs !== expect_res(q, 1'b1) || rdy !== 3'b000) begin
          $display("FAIL random_hold[%0d]: got %h want %h", v, obs, expect_res(q, 1'b1)); miscompares++;
        end
      end
      acc_ready = 1'b1;
      tick();
      vectors++;
      if (obs !== expect_res(q, 1'b0) || rdy !== 3'b111) begin
        $display("FAIL random_release[%0d]: got %h/%b want %h/111", v, obs, rdy, expect_res(q, 1'b0)); miscompares++;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_three_term();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    test_count_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
